// File: rtl/sal_rd_resp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sal_rd_resp_arbiter
// Purpose  : Merges per-bank read-data beats onto one registered AXI R channel,
//            round-robin between banks with the grant held for a whole burst.
// Revision : 1.0 - initial release
// ============================================================================
module sal_rd_resp_arbiter #(
    parameter int BK_CNT     = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BK_CNT-1:0]            bk_rvalid_i,
    output logic [BK_CNT-1:0]            bk_rready_o,
    input  logic [BK_CNT*ID_WIDTH-1:0]   bk_rid_i,
    input  logic [BK_CNT*DATA_WIDTH-1:0] bk_rdata_i,
    input  logic [BK_CNT-1:0]            bk_rlast_i,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic [ID_WIDTH-1:0]          rid_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic [1:0]                   rresp_o,
    output logic                         rlast_o
);

    localparam int IDX_W = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        gnt_q, gnt_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    rvalid_q, rvalid_d;
    logic [ID_WIDTH-1:0]     rid_q, rid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rlast_q, rlast_d;

    logic [ID_WIDTH-1:0]     bk_id   [BK_CNT];
    logic [DATA_WIDTH-1:0]   bk_data [BK_CNT];

    logic                    ld;
    logic                    arb_found;
    logic [IDX_W-1:0]        arb_idx;
    logic [IDX_W:0]          cand;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_vld;
    logic                    accept;
    logic                    beat_last;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(BK_CNT - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Ready is also gated by rst_n so it drops the moment reset is asserted.
    generate
        for (genvar g = 0; g < BK_CNT; g++) begin : g_bank
            assign bk_id[g]       = bk_rid_i[g*ID_WIDTH +: ID_WIDTH];
            assign bk_data[g]     = bk_rdata_i[g*DATA_WIDTH +: DATA_WIDTH];
            assign bk_rready_o[g] = rst_n & ld & sel_vld & (sel_idx == IDX_W'(g));
        end
    endgenerate

    assign ld = ~rvalid_q | rready_i;

    // Search order starts at rr_ptr and wraps modulo BK_CNT.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < BK_CNT; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(BK_CNT)) begin
                cand = cand - (IDX_W+1)'(BK_CNT);
            end
            if (!arb_found && bk_rvalid_i[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_idx   = (state_q == ST_IDLE) ? arb_idx : gnt_q;
        sel_vld   = (state_q == ST_IDLE) ? arb_found : 1'b1;
        accept    = ld & sel_vld & bk_rvalid_i[sel_idx];
        beat_last = bk_rlast_i[sel_idx];
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (beat_last) begin
                        rr_ptr_d = wrap_inc(sel_idx);
                    end else begin
                        gnt_d   = sel_idx;
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (accept && beat_last) begin
                    rr_ptr_d = wrap_inc(gnt_q);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output holding register: data only moves when the slot is free or draining.
    always_comb begin
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rlast_d  = rlast_q;
        if (ld) begin
            rvalid_d = accept;
            if (accept) begin
                rid_d   = bk_id[sel_idx];
                rdata_d = bk_data[sel_idx];
                rlast_d = beat_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rid_o    = rid_q;
    assign rdata_o  = rdata_q;
    assign rlast_o  = rlast_q;
    assign rresp_o  = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_sal_rd_resp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sal_rd_resp_arbiter
// Purpose  : Directed bench for sal_rd_resp_arbiter with per-bank beat queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sal_rd_resp_arbiter;

    localparam int BK  = 4;
    localparam int IDW = 4;
    localparam int DW  = 64;
    localparam int DEP = 64;

    logic              clk;
    logic              rst_n;
    logic [BK-1:0]     bk_rvalid;
    logic [BK-1:0]     bk_rready;
    logic [BK*IDW-1:0] bk_rid;
    logic [BK*DW-1:0]  bk_rdata;
    logic [BK-1:0]     bk_rlast;
    logic              rvalid;
    logic              rready;
    logic [IDW-1:0]    rid;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast;

    int n_tests = 0;
    int n_fail  = 0;

    logic [IDW-1:0] m_id   [BK][DEP];
    logic [DW-1:0]  m_data [BK][DEP];
    logic           m_last [BK][DEP];
    int             head [BK] = '{default: 0};
    int             tail [BK] = '{default: 0};

    sal_rd_resp_arbiter #(.BK_CNT(BK), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bk_rvalid_i (bk_rvalid),
        .bk_rready_o (bk_rready),
        .bk_rid_i    (bk_rid),
        .bk_rdata_i  (bk_rdata),
        .bk_rlast_i  (bk_rlast),
        .rvalid_o    (rvalid),
        .rready_i    (rready),
        .rid_o       (rid),
        .rdata_o     (rdata),
        .rresp_o     (rresp),
        .rlast_o     (rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank models: present head of queue, pop on handshake, flush while in reset.
    always_comb begin
        for (int b = 0; b < BK; b++) begin
            bk_rvalid[b]            = (head[b] != tail[b]);
            bk_rid[b*IDW +: IDW]    = m_id[b][head[b]];
            bk_rdata[b*DW +: DW]    = m_data[b][head[b]];
            bk_rlast[b]             = m_last[b][head[b]];
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < BK; b++) begin
            if (!rst_n) head[b] <= tail[b];
            else if (bk_rvalid[b] && bk_rready[b]) head[b] <= head[b] + 1;
        end
    end

    function automatic logic [DW-1:0] dat(input int t, input int b, input int k);
        return 64'hDA7A_0000_0000_0000 | 64'(t * 256 + b * 16 + k);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int b, input logic [IDW-1:0] id, input logic [DW-1:0] d, input logic l);
        m_id[b][tail[b]]   = id;
        m_data[b][tail[b]] = d;
        m_last[b][tail[b]] = l;
        tail[b]++;
    endtask

    task automatic exp_r(input string tag, input logic v, input logic [IDW-1:0] id,
                         input logic [DW-1:0] d, input logic l);
        chk({tag, ".rvalid"}, 64'(rvalid), 64'(v));
        chk({tag, ".rresp"}, 64'(rresp), 64'd0);
        if (v) begin
            chk({tag, ".rid"}, 64'(rid), 64'(id));
            chk({tag, ".rdata"}, rdata, d);
            chk({tag, ".rlast"}, 64'(rlast), 64'(l));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        rready = 1'b1;
        #7;
        chk("rst.rvalid", 64'(rvalid), 64'd0);
        chk("rst.rid", 64'(rid), 64'd0);
        chk("rst.rdata", rdata, 64'd0);
        chk("rst.rlast", 64'(rlast), 64'd0);
        chk("rst.bk_rready", 64'(bk_rready), 64'd0);
        cyc();
        rst_n = 1'b1;

        // 1: single 4-beat burst from bank 0
        for (int k = 0; k < 4; k++) push(0, 4'd3, dat(1, 0, k), k == 3);
        #1;
        chk("t1.rdy0", 64'(bk_rready), 64'b0001);
        for (int k = 0; k < 4; k++) begin
            cyc();
            exp_r($sformatf("t1.b%0d", k), 1'b1, 4'd3, dat(1, 0, k), k == 3);
        end
        chk("t1.rdy_end", 64'(bk_rready), 64'd0);
        cyc();
        exp_r("t1.idle", 1'b0, 4'd0, 64'd0, 1'b0);

        // 2: banks 0 and 2 together from rr_ptr=0, no gap at switch
        do_reset();
        for (int k = 0; k < 2; k++) push(0, 4'd1, dat(2, 0, k), k == 1);
        for (int k = 0; k < 2; k++) push(2, 4'd2, dat(2, 2, k), k == 1);
        #1;
        chk("t2.rdy0", 64'(bk_rready), 64'b0001);
        cyc(); exp_r("t2.a0", 1'b1, 4'd1, dat(2, 0, 0), 1'b0);
        cyc(); exp_r("t2.a1", 1'b1, 4'd1, dat(2, 0, 1), 1'b1);
        chk("t2.rdy_sw", 64'(bk_rready), 64'b0100);
        cyc(); exp_r("t2.c0", 1'b1, 4'd2, dat(2, 2, 0), 1'b0);
        cyc(); exp_r("t2.c1", 1'b1, 4'd2, dat(2, 2, 1), 1'b1);
        cyc(); exp_r("t2.idle", 1'b0, 4'd0, 64'd0, 1'b0);
        // rr_ptr should now be 3: bank 3 beats bank 0
        push(0, 4'd5, dat(2, 0, 8), 1'b1);
        push(3, 4'd6, dat(2, 3, 8), 1'b1);
        #1;
        chk("t2.rr3", 64'(bk_rready), 64'b1000);
        cyc(); exp_r("t2.f0", 1'b1, 4'd6, dat(2, 3, 8), 1'b1);
        chk("t2.rr0", 64'(bk_rready), 64'b0001);
        cyc(); exp_r("t2.e0", 1'b1, 4'd5, dat(2, 0, 8), 1'b1);
        cyc(); exp_r("t2.idle2", 1'b0, 4'd0, 64'd0, 1'b0);

        // 3: backpressure for 5 cycles mid-burst on bank 1
        for (int k = 0; k < 4; k++) push(1, 4'd7, dat(3, 1, k), k == 3);
        #1;
        chk("t3.rdy1", 64'(bk_rready), 64'b0010);
        cyc(); exp_r("t3.g0", 1'b1, 4'd7, dat(3, 1, 0), 1'b0);
        rready = 1'b0;
        #1;
        chk("t3.rdy_bp", 64'(bk_rready), 64'd0);
        for (int c = 0; c < 5; c++) begin
            cyc();
            exp_r($sformatf("t3.hold%0d", c), 1'b1, 4'd7, dat(3, 1, 0), 1'b0);
            chk($sformatf("t3.rdy_hold%0d", c), 64'(bk_rready), 64'd0);
        end
        rready = 1'b1;
        #1;
        chk("t3.rdy_res", 64'(bk_rready), 64'b0010);
        for (int k = 1; k < 4; k++) begin
            cyc();
            exp_r($sformatf("t3.g%0d", k), 1'b1, 4'd7, dat(3, 1, k), k == 3);
        end
        cyc(); exp_r("t3.idle", 1'b0, 4'd0, 64'd0, 1'b0);

        // 4: lock on bank 1 while bank 0 requests
        for (int k = 0; k < 4; k++) push(1, 4'd8, dat(4, 1, k), k == 3);
        #1;
        chk("t4.rdy1", 64'(bk_rready), 64'b0010);
        cyc(); exp_r("t4.h0", 1'b1, 4'd8, dat(4, 1, 0), 1'b0);
        cyc(); exp_r("t4.h1", 1'b1, 4'd8, dat(4, 1, 1), 1'b0);
        push(0, 4'd9, dat(4, 0, 0), 1'b1);
        #1;
        chk("t4.lock_a", 64'(bk_rready), 64'b0010);
        cyc(); exp_r("t4.h2", 1'b1, 4'd8, dat(4, 1, 2), 1'b0);
        chk("t4.lock_b", 64'(bk_rready), 64'b0010);
        cyc(); exp_r("t4.h3", 1'b1, 4'd8, dat(4, 1, 3), 1'b1);
        chk("t4.rdy0", 64'(bk_rready), 64'b0001);
        cyc(); exp_r("t4.i0", 1'b1, 4'd9, dat(4, 0, 0), 1'b1);
        cyc(); exp_r("t4.idle", 1'b0, 4'd0, 64'd0, 1'b0);

        // 5: fairness with all banks issuing single-beat bursts
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < BK; b++) push(b, 4'(b), dat(5, b, k), 1'b1);
        #1;
        chk("t5.rdy0", 64'(bk_rready), 64'b0001);
        for (int k = 0; k < 8; k++) begin
            cyc();
            exp_r($sformatf("t5.beat%0d", k), 1'b1, 4'(k % 4), dat(5, k % 4, k / 4), 1'b1);
            chk($sformatf("t5.rdy%0d", k), 64'(bk_rready),
                (k < 7) ? (64'd1 << ((k + 1) % 4)) : 64'd0);
        end
        cyc(); exp_r("t5.idle", 1'b0, 4'd0, 64'd0, 1'b0);

        // 6: reset mid-burst with rr_ptr=3, then bank 2 wins over bank 3
        push(2, 4'd2, dat(6, 2, 0), 1'b1);
        cyc(); exp_r("t6.l0", 1'b1, 4'd2, dat(6, 2, 0), 1'b1);
        cyc(); exp_r("t6.idle0", 1'b0, 4'd0, 64'd0, 1'b0);
        for (int k = 0; k < 3; k++) push(3, 4'd3, dat(6, 3, k), k == 2);
        cyc(); exp_r("t6.m0", 1'b1, 4'd3, dat(6, 3, 0), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6.rst_rvalid", 64'(rvalid), 64'd0);
        chk("t6.rst_rdy", 64'(bk_rready), 64'd0);
        chk("t6.rst_rdata", rdata, 64'd0);
        chk("t6.rst_rlast", 64'(rlast), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        push(3, 4'd3, dat(6, 3, 8), 1'b1);
        push(2, 4'd2, dat(6, 2, 8), 1'b1);
        #1;
        chk("t6.rdy2", 64'(bk_rready), 64'b0100);
        cyc(); exp_r("t6.p0", 1'b1, 4'd2, dat(6, 2, 8), 1'b1);
        chk("t6.rdy3", 64'(bk_rready), 64'b1000);
        cyc(); exp_r("t6.n0", 1'b1, 4'd3, dat(6, 3, 8), 1'b1);
        cyc(); exp_r("t6.idle", 1'b0, 4'd0, 64'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
